// File: rtl/csa1.sv
// Registered 3:2 carry-save compressor for staggered-width partial-product rows.
// Optional CSA1_SUM_EN adds a registered carry-propagate sum output for cross-checking.
module csa1 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] a1,
    input  logic [W:0]   a2,
    input  logic [W+1:0] a3,
    output logic [W+1:0] b1,
    output logic [W+1:0] b2,
`ifdef CSA1_SUM_EN
    output logic [W+2:0] sum,
`endif
    output logic         out_valid
);

    // Valid-only stream: in_valid qualifies a1/a2/a3 in the cycle it is high
    // and en is high; out_valid qualifies b1/b2 one enabled edge later.
    // There is no backpressure; a new operand set may arrive every cycle.

    logic [W+1:0] x, y, z;
    logic [W+1:0] s_d;
    logic [W:0]   c_d;
    logic [W+1:0] b1_d, b2_d;
    logic [W+1:0] b1_q, b2_q;
    logic         valid_q;

    always_comb begin
        x    = {2'b00, a1};
        y    = {1'b0, a2};
        z    = a3;
        s_d  = x ^ y ^ z;
        // Top carry is omitted: x and y are both zero in bit W+1.
        c_d  = (x[W:0] & y[W:0]) | (x[W:0] & z[W:0]) | (y[W:0] & z[W:0]);
        b1_d = s_d;
        b2_d = {c_d, 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b1_q    <= '0;
            b2_q    <= '0;
            valid_q <= 1'b0;
        end else if (en) begin
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            valid_q <= in_valid;
        end
    end

    assign b1        = b1_q;
    assign b2        = b2_q;
    assign out_valid = valid_q;

`ifdef CSA1_SUM_EN
    logic [W+2:0] sum_d, sum_q;

    always_comb begin
        sum_d = {3'b000, a1} + {2'b00, a2} + {1'b0, a3};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
`endif

endmodule

// File: tb/tb_csa1.sv
// Self-checking bench for csa1: directed vector table, enable/reset sequences,
// and randomized vectors against an arithmetic reference model.
module tb_csa1;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         in_valid;
    logic [W-1:0] a1;
    logic [W:0]   a2;
    logic [W+1:0] a3;
    logic [W+1:0] b1;
    logic [W+1:0] b2;
    logic         out_valid;
`ifdef CSA1_SUM_EN
    logic [W+2:0] sum;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [W+2:0] exp_q[$];

    csa1 #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .b1        (b1),
        .b2        (b2),
`ifdef CSA1_SUM_EN
        .sum       (sum),
`endif
        .out_valid (out_valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W+2:0] ref_total(input logic [W-1:0] p, input logic [W:0] q,
                                               input logic [W+1:0] r);
        return {3'b000, p} + {2'b00, q} + {1'b0, r};
    endfunction

    // Sum row is the bitwise parity; carry row is whatever remains of the total.
    function automatic logic [W+1:0] ref_b1(input logic [W-1:0] p, input logic [W:0] q,
                                            input logic [W+1:0] r);
        return {2'b00, p} ^ {1'b0, q} ^ r;
    endfunction

    function automatic logic [W+1:0] ref_b2(input logic [W-1:0] p, input logic [W:0] q,
                                            input logic [W+1:0] r);
        logic [W+2:0] t;
        t = ref_total(p, q, r) - {1'b0, ref_b1(p, q, r)};
        return t[W+1:0];
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [W+1:0] eb1, input logic [W+1:0] eb2,
                           input logic ev);
        chk({tag, ".b1"}, 64'(b1), 64'(eb1));
        chk({tag, ".b2"}, 64'(b2), 64'(eb2));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
`ifdef CSA1_SUM_EN
        chk({tag, ".sum"}, 64'(sum), 64'({1'b0, eb1} + {1'b0, eb2}));
`endif
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic v, input logic [W-1:0] p, input logic [W:0] q,
                         input logic [W+1:0] r);
        in_valid = v;
        a1       = p;
        a2       = q;
        a3       = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic         v;
        logic [W-1:0] a1;
        logic [W:0]   a2;
        logic [W+1:0] a3;
        logic [W+1:0] eb1;
        logic [W+1:0] eb2;
        logic         ev;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [W+1:0] hb1, hb2;
        logic [W+2:0] tot, pop;
        logic         v;
        logic [W-1:0] r1;
        logic [W:0]   r2;
        logic [W+1:0] r3;

        tbl[0] = '{1'b1, 32'h88888888, 33'h044444444, 34'h022222222, 34'h0EEEEEEEE, 34'h0, 1'b1};
        tbl[1] = '{1'b1, 32'hFFFFFFFF, 33'h1FFFFFFFF, 34'h3FFFFFFFF, 34'h2FFFFFFFF, 34'h3FFFFFFFE, 1'b1};
        tbl[2] = '{1'b1, 32'h1, 33'h1, 34'h1, 34'h1, 34'h2, 1'b1};
        tbl[3] = '{1'b0, 32'h1, 33'h1, 34'h0, 34'h0, 34'h2, 1'b0};
        tbl[4] = '{1'b1, 32'h0, 33'h0, 34'h0, 34'h0, 34'h0, 1'b1};
        tbl[5] = '{1'b1, 32'h0, 33'h0, 34'h300000000, 34'h300000000, 34'h0, 1'b1};
        tbl[6] = '{1'b1, 32'h0, 33'h100000000, 34'h100000000, 34'h0, 34'h200000000, 1'b1};

        rst_n = 1'b0;
        en    = 1'b0;
        drive(1'b0, '0, '0, '0);
        step();
        step();
        chk_out("reset", '0, '0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].v, tbl[i].a1, tbl[i].a2, tbl[i].a3);
            step();
            chk_out($sformatf("tbl%0d", i), tbl[i].eb1, tbl[i].eb2, tbl[i].ev);
        end
        chk("all_ones.total", 64'({1'b0, tbl[1].eb1} + {1'b0, tbl[1].eb2}), 64'h6FFFFFFFD);

        // Enable low: outputs hold while inputs change.
        drive(1'b1, 32'h12345678, 33'h0ABCDEF01, 34'h2468ACE13);
        step();
        hb1 = ref_b1(32'h12345678, 33'h0ABCDEF01, 34'h2468ACE13);
        hb2 = ref_b2(32'h12345678, 33'h0ABCDEF01, 34'h2468ACE13);
        chk_out("en_load", hb1, hb2, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i[0], $urandom, {1'b1, $urandom}, {2'b11, $urandom});
            step();
            chk_out($sformatf("en_hold%0d", i), hb1, hb2, 1'b1);
        end
        en = 1'b1;
        drive(1'b1, 32'hFFFF0000, 33'h00000FFFF, 34'h0F0F0F0F0);
        step();
        chk_out("en_resume", ref_b1(32'hFFFF0000, 33'h00000FFFF, 34'h0F0F0F0F0),
                ref_b2(32'hFFFF0000, 33'h00000FFFF, 34'h0F0F0F0F0), 1'b1);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", '0, '0, 1'b0);
        drive(1'b1, 32'h1, 33'h2, 34'h4);
        step();
        chk_out("rst_held", '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_out("rst_released", '0, '0, 1'b0);
        step();
        chk_out("first_capture", 34'h7, 34'h0, 1'b1);

        // Randomized stream with a scoreboard of expected totals.
        for (int i = 0; i < 1000; i++) begin
            v  = 1'($urandom_range(0, 3) != 0);
            r1 = $urandom;
            r2 = {1'($urandom), $urandom};
            r3 = {2'($urandom), $urandom};
            if (i % 100 == 0) begin
                r1 = $urandom_range(0, 1) ? '0 : '1;
                r2 = {(W+1){r1[0]}};
                r3 = {(W+2){r1[0]}};
            end
            drive(v, r1, r2, r3);
            tot = ref_total(r1, r2, r3);
            if (v) exp_q.push_back(tot);
            hb1 = ref_b1(r1, r2, r3);
            hb2 = ref_b2(r1, r2, r3);
            step();
            chk_out($sformatf("rnd%0d", i), hb1, hb2, v);
            chk("rnd.b2_lsb", 64'(b2[0]), 64'h0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rnd.sb_empty", 64'h1, 64'h0);
                end else begin
                    pop = exp_q.pop_front();
                    chk("rnd.b1_plus_b2", 64'({1'b0, b1} + {1'b0, b2}), 64'(pop));
                end
            end
        end
        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
